// File: rtl/lcs_responder.sv
// lcs_responder: tick-paced request/acknowledge responder for an LCS bus.
// A request is acknowledged on a tick, the latched address is checked
// against a temperature window, then a fixed delay and a bounded wait for
// request release follow. A release that never comes ends in a one-cycle
// error pulse.
// Optional feature macro: LCS_TEMP_INSERT_EN enables temperature insertion.
// When it is defined, window hits substitute dataTemp on dataTx and advance
// a wrapping temperature pointer. When it is undefined, dataTx always
// carries dataLCS and addrTemp stays 0.
module lcs_responder #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 9,
  parameter int TEMP_AW       = 7,
  parameter int TEMP_DEPTH    = 128,
  parameter int WIN_BASE      = 184,
  parameter int WIN_LEN       = 4,
  parameter int DELAY_TICKS   = 10,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               edgeTx,
  input  logic               SW,
  input  logic               req,
  input  logic [ADDR_W-1:0]  addrLCS,
  input  logic [DATA_W-1:0]  dataLCS,
  input  logic [DATA_W-1:0]  dataTemp,
  output logic               ack,
  output logic [DATA_W-1:0]  dataTx,
  output logic [TEMP_AW-1:0] addrTemp,
  output logic               busy,
  output logic               err
);

  localparam int CNT_W = (DELAY_TICKS > 1) ? $clog2(DELAY_TICKS) : 1;
  localparam int TMO_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  // Window bounds carry one extra bit so WIN_BASE+WIN_LEN-1 cannot wrap.
  localparam logic [ADDR_W:0]    WIN_LO   = (ADDR_W+1)'(WIN_BASE);
  localparam logic [ADDR_W:0]    WIN_HI   = (ADDR_W+1)'(WIN_BASE + WIN_LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DELAY_TICKS - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_TICKS - 1);
  localparam logic [TEMP_AW-1:0] PTR_LAST = TEMP_AW'(TEMP_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DELAY = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_req_meta;
  logic               r_req_s;
  logic               r_sw_meta;
  logic               r_sw_s;
  logic               r_ack;
  logic               r_err;
  logic               r_busy;
  logic               r_en_temp;
  logic [TEMP_AW-1:0] r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [TMO_W-1:0]   r_tmo;
  logic [ADDR_W-1:0]  r_addr_q;

  logic               w_in_win;
  logic               w_hit;
  logic [TEMP_AW-1:0] w_ptr_inc;

  // Two-flop synchronisers for the asynchronous SW and req pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_meta <= 1'b0;
      r_req_s    <= 1'b0;
      r_sw_meta  <= 1'b0;
      r_sw_s     <= 1'b0;
    end else begin
      r_req_meta <= req;
      r_req_s    <= r_req_meta;
      r_sw_meta  <= SW;
      r_sw_s     <= r_sw_meta;
    end
  end

  assign w_in_win  = ({1'b0, r_addr_q} >= WIN_LO) && ({1'b0, r_addr_q} <= WIN_HI);
  assign w_ptr_inc = (r_ptr == PTR_LAST) ? '0 : r_ptr + TEMP_AW'(1);

`ifdef LCS_TEMP_INSERT_EN
  assign w_hit  = r_sw_s & w_in_win;
  assign dataTx = r_en_temp ? dataTemp : dataLCS;
`else
  // Insertion disabled: no hit ever occurs, so enTemp and ptr stay at reset.
  logic w_unused;
  assign w_hit    = 1'b0;
  assign dataTx   = dataLCS;
  assign w_unused = ^{dataTemp, r_sw_s, w_in_win, r_en_temp};
`endif

  // Handshake FSM; every state and counter change is gated by the tick strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_en_temp <= 1'b0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_addr_q  <= '0;
    end else begin
      // err is a single-cycle pulse regardless of tick spacing.
      r_err <= 1'b0;
      if (edgeTx) begin
        case (r_state)
          ST_IDLE: begin
            if (r_req_s) begin
              r_ack    <= 1'b1;
              r_addr_q <= addrLCS;
              r_busy   <= 1'b1;
              r_state  <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            r_ack     <= 1'b0;
            r_cnt     <= '0;
            r_en_temp <= w_hit;
            if (w_hit) begin
              r_ptr <= w_ptr_inc;
            end
            r_state <= ST_DELAY;
          end
          ST_DELAY: begin
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_tmo   <= '0;
              r_state <= ST_WAIT;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_WAIT: begin
            if (!r_req_s) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else if (r_tmo == TMO_LAST) begin
              r_err   <= 1'b1;
              r_tmo   <= '0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_tmo <= r_tmo + TMO_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ack      = r_ack;
  assign err      = r_err;
  assign busy     = r_busy;
  assign addrTemp = r_ptr;

endmodule

// File: tb/tb_lcs_responder.sv
// Bench for lcs_responder: two instances (default depth and depth 4) share
// stimulus. Table-driven transactions, hand-written timing sequences and
// randomized transactions are checked against a transaction-level model.
`timescale 1ns/1ps
module tb_lcs_responder;

  localparam int DATA_W        = 8;
  localparam int ADDR_W        = 9;
  localparam int TEMP_AW       = 7;
  localparam int WIN_BASE      = 184;
  localparam int WIN_LEN       = 4;
  localparam int DELAY_TICKS   = 10;
  localparam int TIMEOUT_TICKS = 64;
  localparam int DEPTH_A       = 128;
  localparam int DEPTH_B       = 4;
`ifdef LCS_TEMP_INSERT_EN
  localparam bit INSERT_ON = 1'b1;
`else
  localparam bit INSERT_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              edgeTx;
  logic              SW;
  logic              req;
  logic [ADDR_W-1:0] addrLCS;
  logic [DATA_W-1:0] dataLCS;
  logic [DATA_W-1:0] dataTemp;

  logic               ack_a, busy_a, err_a;
  logic [DATA_W-1:0]  data_tx_a;
  logic [TEMP_AW-1:0] addr_temp_a;
  logic               ack_b, busy_b, err_b;
  logic [DATA_W-1:0]  data_tx_b;
  logic [TEMP_AW-1:0] addr_temp_b;

  lcs_responder u_dut_a (
    .clk(clk), .rst(rst), .edgeTx(edgeTx), .SW(SW), .req(req),
    .addrLCS(addrLCS), .dataLCS(dataLCS), .dataTemp(dataTemp),
    .ack(ack_a), .dataTx(data_tx_a), .addrTemp(addr_temp_a),
    .busy(busy_a), .err(err_a)
  );

  lcs_responder #(.TEMP_DEPTH(DEPTH_B)) u_dut_b (
    .clk(clk), .rst(rst), .edgeTx(edgeTx), .SW(SW), .req(req),
    .addrLCS(addrLCS), .dataLCS(dataLCS), .dataTemp(dataTemp),
    .ack(ack_b), .dataTx(data_tx_b), .addrTemp(addr_temp_b),
    .busy(busy_b), .err(err_b)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int tick_per = 1;
  int hits     = 0;
  bit en_model = 1'b0;
  bit last_tick;

  typedef struct {
    int addr;
    bit sw;
    bit exp_hit;
  } vec_t;

  vec_t vecs[10];

  // Advance one clock; remember whether that edge carried a tick.
  task automatic step();
    bit pend;
    pend = edgeTx;
    @(posedge clk);
    #1;
    last_tick = pend;
    cyc++;
    edgeTx = ((cyc % tick_per) == 0);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit in_window(input int a);
    return (a >= WIN_BASE) && (a <= WIN_BASE + WIN_LEN - 1);
  endfunction

  task automatic check_outputs(input string tag);
    int exp_d;
    exp_d = en_model ? int'(dataTemp) : int'(dataLCS);
    check({tag, "_addrTemp_a"}, int'(addr_temp_a), hits % DEPTH_A);
    check({tag, "_addrTemp_b"}, int'(addr_temp_b), hits % DEPTH_B);
    check({tag, "_dataTx_a"}, int'(data_tx_a), exp_d);
    check({tag, "_dataTx_b"}, int'(data_tx_b), exp_d);
  endtask

  task automatic wait_ack(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      step();
      if (ack_a) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_ack_seen"}, int'(ok), 1);
    if (ok) check({tag, "_ack_on_tick"}, int'(last_tick), 1);
    check({tag, "_ack_b"}, int'(ack_b), 1);
    check({tag, "_busy_a"}, int'(busy_a), 1);
  endtask

  // ack must last exactly one tick; then the CHECK outcome is visible.
  task automatic ack_phase(input bit exp_hit, input string tag);
    int tk;
    tk = 0;
    for (int n = 0; n < 40 && ack_a; n++) begin
      step();
      tk += int'(last_tick);
    end
    check({tag, "_ack_ticks"}, tk, 1);
    check({tag, "_ack_b_low"}, int'(ack_b), 0);
    en_model = INSERT_ON && exp_hit;
    if (en_model) hits++;
    check_outputs({tag, "_chk"});
  endtask

  // Keep req for some ticks (DELAY ignores it), drop it, wait for idle.
  task automatic hold_then_release(input int hold, input string tag);
    int t, errs, acks;
    t = 0; errs = 0; acks = 0;
    for (int n = 0; t < hold && n < 400; n++) begin
      step();
      t += int'(last_tick);
      errs += int'(err_a) + int'(err_b);
      acks += int'(ack_a) + int'(ack_b);
    end
    req = 1'b0;
    for (int n = 0; n < 400; n++) begin
      step();
      errs += int'(err_a) + int'(err_b);
      acks += int'(ack_a) + int'(ack_b);
      if (!busy_a && !busy_b) break;
    end
    check({tag, "_busy_a_fell"}, int'(busy_a), 0);
    check({tag, "_busy_b_fell"}, int'(busy_b), 0);
    check({tag, "_no_err"}, errs, 0);
    check({tag, "_no_reack"}, acks, 0);
    check_outputs({tag, "_end"});
  endtask

  task automatic run_txn(input int addr, input bit sw, input bit exp_hit,
                         input int hold, input string tag);
    addrLCS  = ADDR_W'(addr);
    SW       = sw;
    dataLCS  = DATA_W'($urandom);
    dataTemp = ~dataLCS;
    req      = 1'b1;
    wait_ack(tag);
    ack_phase(exp_hit, tag);
    hold_then_release(hold, tag);
    $display("txn %s addr=%0d sw=%0d hit=%0d tick_per=%0d addrTemp_a=%0d addrTemp_b=%0d",
             tag, addr, sw, exp_hit, tick_per, addr_temp_a, addr_temp_b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    SW  = 1'b0;
    step();
    step();
    rst = 1'b0;
    hits = 0;
    en_model = 1'b0;
  endtask

  initial begin
    int k, err_k, ack_k, errs;
    vecs[0] = '{184, 1'b1, 1'b1};
    vecs[1] = '{185, 1'b1, 1'b1};
    vecs[2] = '{186, 1'b1, 1'b1};
    vecs[3] = '{187, 1'b1, 1'b1};
    vecs[4] = '{183, 1'b1, 1'b0};
    vecs[5] = '{188, 1'b1, 1'b0};
    vecs[6] = '{185, 1'b0, 1'b0};
    vecs[7] = '{100, 1'b1, 1'b0};
    vecs[8] = '{511, 1'b1, 1'b0};
    vecs[9] = '{184, 1'b1, 1'b1};

    edgeTx   = 1'b1;
    rst      = 1'b1;
    req      = 1'b0;
    SW       = 1'b0;
    addrLCS  = '0;
    dataLCS  = 8'h5A;
    dataTemp = 8'hA5;

    // Reset state.
    do_reset();
    check("rst_ack_a", int'(ack_a), 0);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_err_a", int'(err_a), 0);
    check("rst_busy_b", int'(busy_b), 0);
    check_outputs("rst");

    // Plain request outside the window, then precise busy-fall timing in WAIT.
    tick_per = 1;
    addrLCS  = ADDR_W'(100);
    SW       = 1'b1;
    req      = 1'b1;
    wait_ack("basic");
    ack_phase(1'b0, "basic");
    errs = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      errs += int'(err_a);
    end
    req = 1'b0;
    k = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (!busy_a) begin
        k = n;
        break;
      end
    end
    check("basic_busy_fall_cycles", k, 3);
    check("basic_no_err", errs, 0);
    $display("txn basic addr=100 busy fell after %0d cycles", k);

    // Table: window boundaries, SW gating and pointer wrap on the depth-4 unit.
    foreach (vecs[i]) begin
      tick_per = 1 + (i % 3);
      run_txn(vecs[i].addr, vecs[i].sw, vecs[i].exp_hit, 2 + i, $sformatf("tbl%0d", i));
    end

    // Held request times out: err pulse after delay plus timeout, then re-ack.
    tick_per = 1;
    addrLCS  = ADDR_W'(100);
    SW       = 1'b1;
    req      = 1'b1;
    wait_ack("tmo");
    ack_phase(1'b0, "tmo");
    err_k = 0; ack_k = 0; errs = 0;
    for (k = 2; k <= 90; k++) begin
      step();
      if (err_a) begin
        errs++;
        if (err_k == 0) begin
          err_k = k;
          check("tmo_busy_at_err", int'(busy_a), 0);
          check("tmo_err_b", int'(err_b), 1);
        end
      end
      if (ack_a) begin
        ack_k = k;
        break;
      end
    end
    check("tmo_err_cycle", err_k, 1 + DELAY_TICKS + TIMEOUT_TICKS);
    check("tmo_err_pulses", errs, 1);
    check("tmo_reack_cycle", ack_k, 2 + DELAY_TICKS + TIMEOUT_TICKS);
    $display("txn tmo err at %0d re-ack at %0d", err_k, ack_k);
    ack_phase(1'b0, "tmo2");
    hold_then_release(0, "tmo2");

    // Reset asserted mid-DELAY with ticks every 4th cycle.
    tick_per = 4;
    addrLCS  = ADDR_W'(185);
    SW       = 1'b1;
    req      = 1'b1;
    wait_ack("rdly");
    ack_phase(1'b1, "rdly");
    for (int n = 0; n < 8; n++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    hits = 0;
    en_model = 1'b0;
    check("rdly_ack", int'(ack_a), 0);
    check("rdly_busy_a", int'(busy_a), 0);
    check("rdly_busy_b", int'(busy_b), 0);
    check("rdly_err", int'(err_a), 0);
    check_outputs("rdly_rst");
    errs = 0;
    for (int n = 0; n < 2; n++) begin
      step();
      errs += int'(ack_a) + int'(ack_b);
    end
    check("rdly_no_early_ack", errs, 0);
    wait_ack("rdly2");
    ack_phase(1'b1, "rdly2");
    hold_then_release(3, "rdly2");

    // Randomized transactions against the transaction-level model.
    for (int i = 0; i < 14; i++) begin
      int a;
      bit s;
      tick_per = $urandom_range(1, 4);
      a = ($urandom_range(0, 1) == 1) ? $urandom_range(180, 191) : $urandom_range(0, 511);
      s = 1'($urandom_range(0, 1));
      run_txn(a, s, s && in_window(a), $urandom_range(0, 25), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcs_responder.md
LCS_RESPONDER -- requirements
Module: lcs_responder

Interface
REQ-001 SHALL provide parameter DATA_W, 8, width of dataLCS/dataTemp/dataTx.
REQ-002 SHALL provide parameter ADDR_W, 9, width of addrLCS.
REQ-003 SHALL provide parameter TEMP_AW, 7, width of addrTemp.
REQ-004 SHALL provide parameter TEMP_DEPTH, 128, number of temperature entries; TEMP_DEPTH <= 2^TEMP_AW and >= 1.
REQ-005 SHALL provide parameter WIN_BASE, 184, first LCS address of the temperature window.
REQ-006 SHALL provide parameter WIN_LEN, 4, number of consecutive window addresses, >= 1.
REQ-007 SHALL provide parameter DELAY_TICKS, 10, ticks spent in DELAY, >= 1.
REQ-008 SHALL provide parameter TIMEOUT_TICKS, 64, ticks allowed in WAIT before abort, >= 1.
REQ-009 SHALL have ports: clk in 1, sole clock; rst in 1, synchronous active-high reset.
REQ-010 SHALL have ports: edgeTx in 1, tick strobe (clk domain); FSM advances only on cycles with edgeTx=1.
REQ-011 SHALL have ports: SW in 1, temperature-insert enable (async); req in 1, request (async).
REQ-012 SHALL have ports: addrLCS in ADDR_W, requested LCS address; dataLCS in DATA_W; dataTemp in DATA_W.
REQ-013 SHALL have ports: ack out 1; dataTx out DATA_W; addrTemp out TEMP_AW; busy out 1, state != IDLE; err out 1, one-cycle timeout pulse.

Function
REQ-014 SW and req SHALL each pass a 2-flop synchroniser clocked every clk cycle (reqS, swS); FSM uses only synchronised values.
REQ-015 FSM states SHALL be IDLE, CHECK, DELAY, WAIT; no transition or counter change on cycles with edgeTx=0.
REQ-016 IDLE: on tick with reqS=1 -> ack=1, addrLCS latched into addrQ, go CHECK.
REQ-017 CHECK: on tick -> ack=0, cnt=0, go DELAY; hit = swS=1 and WIN_BASE <= addrQ <= WIN_BASE+WIN_LEN-1 (comparison at ADDR_W+1 bits, no overflow).
REQ-018 On hit: enTemp=1 and ptr advances by 1, wrapping TEMP_DEPTH-1 -> 0; on miss: enTemp=0, ptr unchanged.
REQ-019 DELAY: each tick cnt+1; tick with cnt=DELAY_TICKS-1 -> cnt=0, go WAIT, tmo=0.
REQ-020 WAIT: tick with reqS=0 -> IDLE; tick with reqS=1 -> tmo+1; tick with reqS=1 and tmo=TIMEOUT_TICKS-1 -> err=1 for exactly one clk cycle, tmo=0, go IDLE.
REQ-021 req deassertion during CHECK or DELAY SHALL be ignored; only WAIT observes it.
REQ-022 addrTemp SHALL equal ptr combinationally; dataTx SHALL be dataTemp when enTemp=1, else dataLCS (combinational mux).
REQ-023 enTemp SHALL hold its value from CHECK until the next CHECK.
REQ-024 Latency: req pin rise to ack = 2 clk sync + wait for next tick; ack high exactly from IDLE tick to CHECK tick.
REQ-025 busy SHALL be registered-state-derived, glitch-free.

Reset
REQ-026 On clk edge with rst=1: state=IDLE, ack=0, err=0, enTemp=0, ptr=0, cnt=0, tmo=0, addrQ=0, synchronisers=0; applies mid-transaction, overrides edgeTx.
REQ-027 After reset release, dataTx=dataLCS and addrTemp=0.

Configuration
REQ-028 Macro LCS_TEMP_INSERT_EN defined: REQ-017/018/022 temperature insertion active.
REQ-029 Macro undefined: hit forced 0, enTemp constant 0, ptr constant 0, dataTx=dataLCS always; handshake, DELAY, WAIT, timeout unchanged.

Verification
REQ-030 Reset then req=1, edgeTx every cycle, addrLCS=100, SW=1 -> ack high 1 tick, dataTx=dataLCS, addrTemp=0, busy falls 1 tick after req=0 in WAIT.
REQ-031 SW=1, four requests addrLCS=184..187 -> addrTemp 1,2,3,4 after each CHECK, dataTx=dataTemp after each.
REQ-032 TEMP_DEPTH=4, five hits -> addrTemp 1,2,3,0,1 (wrap).
REQ-033 req held high, TIMEOUT_TICKS=64, DELAY_TICKS=10 -> err single-cycle pulse 64 ticks after WAIT entry, state IDLE, then new ack next tick.
REQ-034 edgeTx every 4th cycle, rst=1 asserted in DELAY -> all outputs reset next edge, no further ack until reqS=1 on a tick.
REQ-035 Macro undefined, SW=1, addrLCS=185 -> dataTx=dataLCS, addrTemp=0 throughout.
